lrrr_ctrl: RTL and testbench

Encounter controller for the Lrrr boss sprite. It generates the `waiting` and `toggleY` commands that the boss trajectory block consumes, and reads back that block's `topLeftX`/`topLeftY`. It also tracks boss hit points and issues shot requests to the enemy-projectile block through a req/ack handshake. It sits between the game-level FSM and collision detector on one side and the Lrrr mover and projectile logic on the other.

---
 rtl/lrrr_pkg.sv | 35 +++
 rtl/lrrr_ctrl_frame_timer.sv | 40 ++++
 rtl/lrrr_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_lrrr_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lrrr_pkg.sv
// Shared types and constants for the Lrrr boss encounter controller.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package lrrr_pkg;

  // Encounter phases of the boss fight.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INTRO  = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_DYING  = 3'd3,
    ST_DEAD   = 3'd4
  } lrrr_state_t;

  // Visible screen limits; shot spawn points are clamped to these.
  localparam logic [10:0] SCREEN_MAX_X = 11'd639;
  localparam logic [10:0] SCREEN_MAX_Y = 11'd479;

  // Width of every frame timer; all frame-count parameters must fit (1..255).
  localparam int TMR_W = 8;

  // 12-bit add of a position and an offset, clamped to a screen limit.
  function automatic logic [10:0] sat_add(input logic [10:0] base,
                                          input logic [11:0] offs,
                                          input logic [10:0] lim);
    logic [11:0] sum;
    sum = {1'b0, base} + offs;
    if (sum > {1'b0, lim}) begin
      sat_add = lim;
    end else begin
      sat_add = sum[10:0];
    end
  endfunction

endpackage

// File: rtl/lrrr_ctrl_frame_timer.sv
// Frame down-counter: loads a frame count, decrements on enabled startOfFrame ticks.
// Latency: o_expired is combinational, high in the clock of the tick that reaches zero.
// Backpressure: none; holds at zero until reloaded, clear has priority over load.
module frame_timer
  import lrrr_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         i_tick,
  input  logic         i_en,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_load_val,
  output logic         o_expired
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_cnt;
  logic         w_step;

  assign w_step    = i_tick & i_en & (r_cnt != '0);
  assign o_expired = i_tick & i_en & (r_cnt == ONE);

  // Count register: clear, then load, then decrement on an enabled tick.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (w_step) begin
      r_cnt <= r_cnt - ONE;
    end
  end

endmodule

// File: rtl/lrrr_ctrl.sv
// Lrrr boss encounter controller: intro hold, toggleY pacing, shot requests, hit points.
// Latency: every output is registered, 1 clock after the qualifying input.
// Backpressure: fireReq/fireX/fireY hold until fireAck; fire timer pauses while pending.
module lrrr_ctrl
  import lrrr_pkg::*;
#(
  parameter int HIT_POINTS    = 8,
  parameter int INTRO_FRAMES  = 60,
  parameter int TOGGLE_FRAMES = 45,
  parameter int FIRE_FRAMES   = 20,
  parameter int FLASH_FRAMES  = 6,
  parameter int DYING_FRAMES  = 30,
  parameter int SPRITE_W      = 64,
  parameter int SPRITE_H      = 64
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        bossStart,
  input  logic        hit,
  input  logic [10:0] topLeftX,
  input  logic [10:0] topLeftY,
  input  logic        fireAck,
  output logic        waiting,
  output logic        toggleY,
  output logic        fireReq,
  output logic [10:0] fireX,
  output logic [10:0] fireY,
  output logic        flash,
  output logic [3:0]  hitsLeft,
  output logic        bossDead
);

  localparam logic [3:0]       HP_LOAD     = 4'(HIT_POINTS);
  localparam logic [TMR_W-1:0] INTRO_LOAD  = TMR_W'(INTRO_FRAMES);
  localparam logic [TMR_W-1:0] TOGGLE_LOAD = TMR_W'(TOGGLE_FRAMES);
  localparam logic [TMR_W-1:0] FIRE_LOAD   = TMR_W'(FIRE_FRAMES);
  localparam logic [TMR_W-1:0] FLASH_LOAD  = TMR_W'(FLASH_FRAMES);
  localparam logic [TMR_W-1:0] DYING_LOAD  = TMR_W'(DYING_FRAMES);
  localparam logic [11:0]      SPAWN_OFS_X = 12'(SPRITE_W / 2);
  localparam logic [11:0]      SPAWN_OFS_Y = 12'(SPRITE_H);

  lrrr_state_t r_state, w_state_nxt;

  logic        r_waiting,   w_waiting_nxt;
  logic        r_toggle,    w_toggle_nxt;
  logic        r_fire_req,  w_fire_req_nxt;
  logic [10:0] r_fire_x,    w_fire_x_nxt;
  logic [10:0] r_fire_y,    w_fire_y_nxt;
  logic        r_flash,     w_flash_nxt;
  logic [3:0]  r_hits_left, w_hits_left_nxt;
  logic        r_boss_dead, w_boss_dead_nxt;

  // Qualified events.
  logic w_in_active;
  logic w_start_ok;
  logic w_hit_ok;
  logic w_kill;
  logic w_ack_ok;
  logic w_intro_done;

  // Timer controls and expiry pulses.
  logic             w_phase_load, w_phase_en, w_phase_exp;
  logic [TMR_W-1:0] w_phase_val;
  logic             w_tog_load, w_tog_en, w_tog_exp;
  logic             w_fire_load, w_fire_clear, w_fire_en, w_fire_exp;
  logic             w_flash_load, w_flash_clear, w_flash_en, w_flash_exp;

  assign w_in_active  = (r_state == ST_ACTIVE);
  assign w_start_ok   = bossStart & ((r_state == ST_IDLE) | (r_state == ST_DEAD));
  // While flashing the boss is invulnerable, so the hit is dropped entirely.
  assign w_hit_ok     = hit & w_in_active & ~r_flash;
  assign w_kill       = w_hit_ok & (r_hits_left == 4'd1);
  // An ack only counts against an outstanding request.
  assign w_ack_ok     = fireAck & w_in_active & r_fire_req;
  assign w_intro_done = (r_state == ST_INTRO) & w_phase_exp;

  // One timer serves both the intro hold and the death animation.
  assign w_phase_load = w_start_ok | w_kill;
  assign w_phase_val  = w_kill ? DYING_LOAD : INTRO_LOAD;
  assign w_phase_en   = (r_state == ST_INTRO) | (r_state == ST_DYING);

  // toggleY pacing restarts itself on every expiry.
  assign w_tog_load   = w_intro_done | w_tog_exp;
  assign w_tog_en     = w_in_active;

  // Fire interval is counted only while no request is outstanding.
  assign w_fire_load  = w_intro_done | w_ack_ok;
  assign w_fire_clear = w_kill;
  assign w_fire_en    = w_in_active & ~r_fire_req;

  // A hit in the same clock as startOfFrame loads first; counting starts next frame.
  assign w_flash_load  = w_hit_ok;
  assign w_flash_clear = w_kill;
  assign w_flash_en    = w_in_active & r_flash;

  frame_timer #(.W(TMR_W)) u_phase_tmr (
    .clk        (clk),
    .resetN     (resetN),
    .i_tick     (startOfFrame),
    .i_en       (w_phase_en),
    .i_load     (w_phase_load),
    .i_clear    (1'b0),
    .i_load_val (w_phase_val),
    .o_expired  (w_phase_exp)
  );

  frame_timer #(.W(TMR_W)) u_toggle_tmr (
    .clk        (clk),
    .resetN     (resetN),
    .i_tick     (startOfFrame),
    .i_en       (w_tog_en),
    .i_load     (w_tog_load),
    .i_clear    (1'b0),
    .i_load_val (TOGGLE_LOAD),
    .o_expired  (w_tog_exp)
  );

  frame_timer #(.W(TMR_W)) u_fire_tmr (
    .clk        (clk),
    .resetN     (resetN),
    .i_tick     (startOfFrame),
    .i_en       (w_fire_en),
    .i_load     (w_fire_load),
    .i_clear    (w_fire_clear),
    .i_load_val (FIRE_LOAD),
    .o_expired  (w_fire_exp)
  );

  frame_timer #(.W(TMR_W)) u_flash_tmr (
    .clk        (clk),
    .resetN     (resetN),
    .i_tick     (startOfFrame),
    .i_en       (w_flash_en),
    .i_load     (w_flash_load),
    .i_clear    (w_flash_clear),
    .i_load_val (FLASH_LOAD),
    .o_expired  (w_flash_exp)
  );

  // Next state and next value of every registered output.
  always_comb begin
    w_state_nxt     = r_state;
    w_toggle_nxt    = 1'b0;
    w_fire_req_nxt  = r_fire_req;
    w_fire_x_nxt    = r_fire_x;
    w_fire_y_nxt    = r_fire_y;
    w_flash_nxt     = r_flash;
    w_hits_left_nxt = r_hits_left;
    w_boss_dead_nxt = r_boss_dead;

    case (r_state)
      ST_IDLE, ST_DEAD: begin
        w_flash_nxt = 1'b0;
        if (bossStart) begin
          w_state_nxt     = ST_INTRO;
          w_hits_left_nxt = HP_LOAD;
          w_boss_dead_nxt = 1'b0;
        end
      end

      ST_INTRO: begin
        if (w_phase_exp) begin
          w_state_nxt = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        w_toggle_nxt = w_tog_exp;
        if (w_ack_ok) begin
          w_fire_req_nxt = 1'b0;
        end else if (w_fire_exp) begin
          w_fire_req_nxt = 1'b1;
          w_fire_x_nxt   = sat_add(topLeftX, SPAWN_OFS_X, SCREEN_MAX_X);
          w_fire_y_nxt   = sat_add(topLeftY, SPAWN_OFS_Y, SCREEN_MAX_Y);
        end
        if (w_flash_exp) begin
          w_flash_nxt = 1'b0;
        end
        if (w_hit_ok) begin
          w_hits_left_nxt = r_hits_left - 4'd1;
          w_flash_nxt     = 1'b1;
          if (w_kill) begin
            w_state_nxt    = ST_DYING;
            w_fire_req_nxt = 1'b0;
          end
        end
      end

      ST_DYING: begin
        w_fire_req_nxt = 1'b0;
        if (startOfFrame) begin
          w_flash_nxt = ~r_flash;
        end
        if (w_phase_exp) begin
          w_state_nxt     = ST_DEAD;
          w_flash_nxt     = 1'b0;
          w_boss_dead_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // The mover only drifts while the boss is fighting or dying.
    w_waiting_nxt = (w_state_nxt == ST_IDLE) | (w_state_nxt == ST_INTRO) |
                    (w_state_nxt == ST_DEAD);
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= ST_IDLE;
      r_waiting   <= 1'b1;
      r_toggle    <= 1'b0;
      r_fire_req  <= 1'b0;
      r_fire_x    <= 11'd0;
      r_fire_y    <= 11'd0;
      r_flash     <= 1'b0;
      r_hits_left <= HP_LOAD;
      r_boss_dead <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_waiting   <= w_waiting_nxt;
      r_toggle    <= w_toggle_nxt;
      r_fire_req  <= w_fire_req_nxt;
      r_fire_x    <= w_fire_x_nxt;
      r_fire_y    <= w_fire_y_nxt;
      r_flash     <= w_flash_nxt;
      r_hits_left <= w_hits_left_nxt;
      r_boss_dead <= w_boss_dead_nxt;
    end
  end

  assign waiting  = r_waiting;
  assign toggleY  = r_toggle;
  assign fireReq  = r_fire_req;
  assign fireX    = r_fire_x;
  assign fireY    = r_fire_y;
  assign flash    = r_flash;
  assign hitsLeft = r_hits_left;
  assign bossDead = r_boss_dead;

endmodule

// File: tb/tb_lrrr_ctrl.sv
// Bench for lrrr_ctrl: directed scenarios plus random stimulus against a frame-level model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: fireAck driven by the scenarios, withheld or returned at random.
module tb_lrrr_ctrl;

  localparam int HP    = 8;
  localparam int INTRO = 60;
  localparam int TOG   = 45;
  localparam int FIRE  = 20;
  localparam int FLSH  = 6;
  localparam int DYING = 30;
  localparam int FCLK  = 4;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic        startOfFrame = 1'b0, bossStart = 1'b0, hit = 1'b0, fireAck = 1'b0;
  logic [10:0] topLeftX = 11'd0, topLeftY = 11'd0;
  logic        waiting, toggleY, fireReq, flash, bossDead;
  logic [10:0] fireX, fireY;
  logic [3:0]  hitsLeft;

  int checks = 0;
  int failures = 0;

  lrrr_ctrl #(
    .HIT_POINTS(HP), .INTRO_FRAMES(INTRO), .TOGGLE_FRAMES(TOG), .FIRE_FRAMES(FIRE),
    .FLASH_FRAMES(FLSH), .DYING_FRAMES(DYING), .SPRITE_W(64), .SPRITE_H(64)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .bossStart(bossStart),
    .hit(hit), .topLeftX(topLeftX), .topLeftY(topLeftY), .fireAck(fireAck),
    .waiting(waiting), .toggleY(toggleY), .fireReq(fireReq), .fireX(fireX), .fireY(fireY),
    .flash(flash), .hitsLeft(hitsLeft), .bossDead(bossDead)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: encounter phases counted in frames ----------------
  localparam int M_IDLE = 0, M_INTRO = 1, M_ACTIVE = 2, M_DYING = 3, M_DEAD = 4;
  int m_mode = M_IDLE, m_frames = 0, m_tog = 0, m_fire = 0, m_flash_n = 0, m_hp = HP;
  int m_fx = 0, m_fy = 0;
  bit m_req = 0, m_flash = 0, m_dead = 0, m_toggle = 0;

  always @(posedge clk or negedge resetN) begin : model
    bit fb;
    if (!resetN) begin
      m_mode = M_IDLE; m_frames = 0; m_tog = 0; m_fire = 0; m_flash_n = 0; m_hp = HP;
      m_fx = 0; m_fy = 0; m_req = 0; m_flash = 0; m_dead = 0; m_toggle = 0;
    end else begin
      fb = m_flash;
      m_toggle = 0;
      case (m_mode)
        M_IDLE, M_DEAD: if (bossStart) begin
          m_mode = M_INTRO; m_hp = HP; m_frames = 0; m_dead = 0;
        end
        M_INTRO: if (startOfFrame) begin
          m_frames++;
          if (m_frames == INTRO) begin m_mode = M_ACTIVE; m_tog = 0; m_fire = 0; end
        end
        M_ACTIVE: begin
          if (startOfFrame) begin
            m_tog++;
            if (m_tog == TOG) begin m_toggle = 1; m_tog = 0; end
          end
          if (m_req) begin
            if (fireAck) begin m_req = 0; m_fire = 0; end
          end else if (startOfFrame) begin
            m_fire++;
            if (m_fire == FIRE) begin
              m_req = 1;
              m_fx = (int'(topLeftX) + 32 > 639) ? 639 : int'(topLeftX) + 32;
              m_fy = (int'(topLeftY) + 64 > 479) ? 479 : int'(topLeftY) + 64;
            end
          end
          if (fb && startOfFrame) begin
            m_flash_n++;
            if (m_flash_n == FLSH) m_flash = 0;
          end
          if (hit && !fb) begin
            m_hp--; m_flash = 1; m_flash_n = 0;
            if (m_hp == 0) begin m_mode = M_DYING; m_req = 0; m_frames = 0; end
          end
        end
        M_DYING: if (startOfFrame) begin
          m_flash = !m_flash;
          m_frames++;
          if (m_frames == DYING) begin m_mode = M_DEAD; m_flash = 0; m_dead = 1; end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  function automatic logic [30:0] dut_vec();
    return {waiting, toggleY, fireReq, fireX, fireY, flash, hitsLeft, bossDead};
  endfunction

  function automatic logic [30:0] exp_vec();
    logic w;
    w = (m_mode == M_IDLE) || (m_mode == M_INTRO) || (m_mode == M_DEAD);
    return {w, m_toggle, m_req, 11'(m_fx), 11'(m_fy), m_flash, 4'(m_hp), m_dead};
  endfunction

  // Drive one clock of inputs, then sample point just after the rising edge.
  task automatic drive_cycle(input logic s, input logic h, input logic a, input logic b);
    startOfFrame = s; hit = h; fireAck = a; bossStart = b;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #3 resetN = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== {1'b1, 1'b0, 1'b0, 11'd0, 11'd0, 1'b0, 4'd8, 1'b0}) begin
      failures++; $display("FAIL reset_values got=%h want=%h", dut_vec(),
                           {1'b1, 1'b0, 1'b0, 11'd0, 11'd0, 1'b0, 4'd8, 1'b0});
    end
    @(posedge clk); #1;
    resetN = 1'b1;
    for (int c = 0; c < 3 * FCLK; c++) begin
      drive_cycle(c % FCLK == 0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL idle_model got=%h want=%h", dut_vec(), exp_vec());
      end
    end
    checks++;
    if (waiting !== 1'b1) begin failures++; $display("FAIL idle_waiting got=%b want=1", waiting); end
  endtask

  task automatic test_intro();
    int n;
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({waiting, hitsLeft} !== {1'b1, 4'd8}) begin
      failures++; $display("FAIL intro_start got=%b/%0d want=1/8", waiting, hitsLeft);
    end
    n = 0;
    for (int f = 0; f < 100 && waiting; f++) begin
      for (int c = 0; c < FCLK; c++) begin
        if (c == 0) n++;
        drive_cycle(c == 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
          failures++; if (failures < 30) $display("FAIL intro_model got=%h want=%h", dut_vec(), exp_vec());
        end
        if (!waiting) break;
      end
    end
    checks++;
    if (n !== INTRO || waiting !== 1'b0) begin
      failures++; $display("FAIL intro_frames got=%0d waiting=%b want=%0d waiting=0", n, waiting, INTRO);
    end
    checks++;
    if (hitsLeft !== 4'd8) begin failures++; $display("FAIL intro_hp got=%0d want=8", hitsLeft); end
  endtask

  task automatic test_toggle();
    int cnt, first, second;
    cnt = 0; first = -1; second = -1;
    for (int f = 1; f <= 100; f++) begin
      for (int c = 0; c < FCLK; c++) begin
        drive_cycle(c == 0, 1'b0, fireReq, 1'b0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
          failures++; if (failures < 30) $display("FAIL toggle_model got=%h want=%h", dut_vec(), exp_vec());
        end
        if (toggleY) begin
          cnt++;
          if (cnt == 1) first = f; else if (cnt == 2) second = f;
        end
      end
    end
    checks++;
    if (cnt !== 2 || first !== TOG || second !== 2 * TOG) begin
      failures++; $display("FAIL toggle_pulses got=%0d@%0d,%0d want=2@%0d,%0d", cnt, first, second, TOG, 2 * TOG);
    end
  endtask

  task automatic test_fire();
    bit seen;
    int n;
    topLeftX = 11'd600; topLeftY = 11'd430;
    if (fireReq) drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    seen = 0;
    for (int f = 0; f < 30 && !seen; f++) begin
      for (int c = 0; c < FCLK; c++) begin
        drive_cycle(c == 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
          failures++; if (failures < 30) $display("FAIL fire_model got=%h want=%h", dut_vec(), exp_vec());
        end
        if (fireReq) begin seen = 1; break; end
      end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL fire_timeout got=no request want=request"); end
    checks++;
    if ({fireX, fireY} !== {11'd632, 11'd479}) begin
      failures++; $display("FAIL fire_xy got=%0d,%0d want=632,479", fireX, fireY);
    end
    topLeftX = 11'd100; topLeftY = 11'd50;
    for (int k = 0; k < 5; k++) begin
      drive_cycle(k == 2, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({fireReq, fireX, fireY} !== {1'b1, 11'd632, 11'd479}) begin
        failures++; $display("FAIL fire_hold got=%b %0d,%0d want=1 632,479", fireReq, fireX, fireY);
      end
    end
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (fireReq !== 1'b0) begin failures++; $display("FAIL fire_ack_drop got=%b want=0", fireReq); end
    n = 0;
    for (int f = 0; f < 40 && !fireReq; f++) begin
      for (int c = 0; c < FCLK; c++) begin
        if (c == 0) n++;
        drive_cycle(c == 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
          failures++; if (failures < 30) $display("FAIL fire2_model got=%h want=%h", dut_vec(), exp_vec());
        end
        if (fireReq) break;
      end
    end
    checks++;
    if (n !== FIRE || {fireX, fireY} !== {11'd132, 11'd114}) begin
      failures++; $display("FAIL fire_interval got=%0d frames %0d,%0d want=%0d frames 132,114", n, fireX, fireY, FIRE);
    end
  endtask

  task automatic test_hits();
    int n;
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({hitsLeft, flash} !== {4'd7, 1'b1}) begin
      failures++; $display("FAIL hit1 got=%0d/%b want=7/1", hitsLeft, flash);
    end
    n = 0;
    for (int f = 0; f < 20 && flash; f++) begin
      for (int c = 0; c < FCLK; c++) begin
        if (c == 0 && flash) n++;
        drive_cycle(c == 0, f == 1 && c == 2, fireReq, 1'b0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
          failures++; if (failures < 30) $display("FAIL hits_model got=%h want=%h", dut_vec(), exp_vec());
        end
      end
    end
    checks++;
    if (n !== FLSH || hitsLeft !== 4'd7) begin
      failures++; $display("FAIL flash_len got=%0d hp=%0d want=%0d hp=7", n, hitsLeft, FLSH);
    end
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (hitsLeft !== 4'd6) begin failures++; $display("FAIL hit3 got=%0d want=6", hitsLeft); end
  endtask

  task automatic test_death();
    bit seen;
    int n, bad;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 8 * FCLK; c++) begin
        drive_cycle(c % FCLK == 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
          failures++; if (failures < 30) $display("FAIL death_model got=%h want=%h", dut_vec(), exp_vec());
        end
      end
      drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    end
    checks++;
    if (hitsLeft !== 4'd1) begin failures++; $display("FAIL death_hp1 got=%0d want=1", hitsLeft); end
    seen = 0;
    for (int f = 0; f < 40 && !seen; f++) begin
      for (int c = 0; c < FCLK; c++) begin
        drive_cycle(c == 0, 1'b0, 1'b0, 1'b0);
        if (f >= 8 && fireReq) seen = 1;
      end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL death_req_timeout got=no request want=request"); end
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({fireReq, waiting, hitsLeft, bossDead} !== {1'b0, 1'b0, 4'd0, 1'b0}) begin
      failures++; $display("FAIL kill got=req%b wait%b hp%0d dead%b want=req0 wait0 hp0 dead0",
                           fireReq, waiting, hitsLeft, bossDead);
    end
    n = 0; bad = 0;
    for (int f = 0; f < 40 && !waiting; f++) begin
      for (int c = 0; c < FCLK; c++) begin
        if (c == 0 && !waiting) n++;
        drive_cycle(c == 0, c == 1, 1'b1, c == 2);
        checks++;
        if (dut_vec() !== exp_vec()) begin
          failures++; if (failures < 30) $display("FAIL dying_model got=%h want=%h", dut_vec(), exp_vec());
        end
        if (toggleY || fireReq) bad++;
        if (waiting) break;
      end
    end
    checks++;
    if (n !== DYING || bad !== 0 || {bossDead, flash} !== 2'b10) begin
      failures++; $display("FAIL dying got=%0d frames bad=%0d dead%b flash%b want=%0d frames bad=0 dead1 flash0",
                           n, bad, bossDead, flash, DYING);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({hitsLeft, bossDead, waiting} !== {4'd8, 1'b0, 1'b1}) begin
      failures++; $display("FAIL restart got=hp%0d dead%b wait%b want=hp8 dead0 wait1", hitsLeft, bossDead, waiting);
    end
  endtask

  task automatic test_random();
    int left;
    left = 0;
    for (int c = 0; c < 6000; c++) begin
      logic s;
      s = (left == 0);
      left = s ? $urandom_range(2, 5) : left - 1;
      topLeftX = 11'($urandom_range(0, 2047));
      topLeftY = 11'($urandom_range(0, 2047));
      drive_cycle(s, $urandom_range(0, 29) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 299) == 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; if (failures < 30) $display("FAIL random_model t=%0t got=%h want=%h", $time, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    resetN = 1'b0;
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    resetN = 1'b1;
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    seen = 0;
    for (int f = 0; f < 120 && !seen; f++) begin
      for (int c = 0; c < FCLK; c++) begin
        drive_cycle(c == 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
          failures++; if (failures < 30) $display("FAIL arst_model got=%h want=%h", dut_vec(), exp_vec());
        end
        if (fireReq) seen = 1;
      end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL arst_req_timeout got=no request want=request"); end
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({waiting, fireReq, flash} !== 3'b011) begin
      failures++; $display("FAIL arst_pre got=%b want=011", {waiting, fireReq, flash});
    end
    #2 resetN = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== {1'b1, 1'b0, 1'b0, 11'd0, 11'd0, 1'b0, 4'd8, 1'b0}) begin
      failures++; $display("FAIL arst_values got=%h want=%h", dut_vec(),
                           {1'b1, 1'b0, 1'b0, 11'd0, 11'd0, 1'b0, 4'd8, 1'b0});
    end
    @(posedge clk); #1;
    resetN = 1'b1;
  endtask

  initial begin
    test_reset();
    test_intro();
    test_toggle();
    test_fire();
    test_hits();
    test_death();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog got=still running want=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
